// File: rtl/klp32_commit_checker.sv
// Self-checking commit monitor: compares committed KLP32 results against a preloaded
// expectation table, counting checks/passes and capturing the first mismatch.
module klp32_commit_checker #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned CNT_W  = 16,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CHW   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int unsigned DW    = NUM_CH * XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load_en,
  input  logic [AW-1:0]     i_load_addr,
  input  logic [DW-1:0]     i_load_data,
  input  logic [NUM_CH-1:0] i_load_mask,
  input  logic [AW:0]       i_num_entries,
  input  logic              i_stop_on_fail,
  input  logic              i_start,
  input  logic              i_commit_valid,
  input  logic [DW-1:0]     i_commit_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pass,
  output logic [CNT_W-1:0]  o_num_checks,
  output logic [CNT_W-1:0]  o_num_passes,
  output logic              o_fail_valid,
  output logic [AW-1:0]     o_fail_index,
  output logic [CHW-1:0]    o_fail_ch,
  output logic [XLEN-1:0]   o_fail_actual,
  output logic [XLEN-1:0]   o_fail_expected,
  output logic              o_overrun
);

  localparam int unsigned IW = $clog2(NUM_CH + 1);
  localparam int unsigned SW = CNT_W + IW;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]        state, stateNext;
  logic [AW:0]       ptr, ptrNext, numEnt, numEntNext;
  logic              stopOnFail, stopOnFailNext;
  logic              s1Valid, s1ValidNext;
  logic [AW-1:0]     s1Index;
  logic [DW-1:0]     s1Data, s1Exp;
  logic [NUM_CH-1:0] s1Mask;
  logic              accept, finish, anyFail, lastEntry;
  logic [NUM_CH-1:0] mism;
  logic [CHW-1:0]    firstCh;
  logic [IW-1:0]     chkInc, passInc;
  logic [SW-1:0]     chkSum, passSum;
  logic [CNT_W-1:0]  checksNext, passesNext;
  logic              failValidNext, overrunNext, busyNext, doneNext, passNext;
  logic [AW-1:0]     failIndexNext;
  logic [CHW-1:0]    failChNext;
  logic [XLEN-1:0]   failActNext, failExpNext;

  logic [DW-1:0]     tblData [DEPTH];
  logic [NUM_CH-1:0] tblMask [DEPTH];

  // Per-channel compare of the stage-1 entry, lowest mismatching channel wins
  always_comb begin
    mism    = '0;
    firstCh = '0;
    chkInc  = '0;
    passInc = '0;
    for (int c = 0; c < int'(NUM_CH); c++) begin
      if (s1Mask[c]) begin
        chkInc = chkInc + IW'(1);
        if (s1Data[c*XLEN +: XLEN] == s1Exp[c*XLEN +: XLEN]) passInc = passInc + IW'(1);
        else mism[c] = 1'b1;
      end
    end
    for (int c = int'(NUM_CH) - 1; c >= 0; c--) begin
      if (mism[c]) firstCh = CHW'(c);
    end
    anyFail   = |mism;
    lastEntry = ((AW+1)'(s1Index) == (numEnt - (AW+1)'(1)));
    chkSum    = SW'(o_num_checks) + SW'(chkInc);
    passSum   = SW'(o_num_passes) + SW'(passInc);
  end

  always_comb begin
    stateNext      = state;
    ptrNext        = ptr;
    numEntNext     = numEnt;
    stopOnFailNext = stopOnFail;
    s1ValidNext    = 1'b0;
    accept         = 1'b0;
    finish         = 1'b0;
    checksNext     = o_num_checks;
    passesNext     = o_num_passes;
    failValidNext  = o_fail_valid;
    failIndexNext  = o_fail_index;
    failChNext     = o_fail_ch;
    failActNext    = o_fail_actual;
    failExpNext    = o_fail_expected;
    overrunNext    = o_overrun;
    case (state)
      RUN: begin
        if (numEnt == '0) begin
          finish = 1'b1;
        end else if (s1Valid) begin
          checksNext = (chkSum > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(chkSum);
          passesNext = (passSum > SW'(CNT_MAX)) ? CNT_MAX : CNT_W'(passSum);
          if (anyFail && !o_fail_valid) begin
            failValidNext = 1'b1;
            failIndexNext = s1Index;
            failChNext    = firstCh;
            failActNext   = s1Data[firstCh*XLEN +: XLEN];
            failExpNext   = s1Exp[firstCh*XLEN +: XLEN];
          end
          finish = lastEntry || (stopOnFail && anyFail);
        end
        // A commit captured on the finishing edge is dropped with the run
        accept      = i_commit_valid && (ptr < numEnt) && !finish;
        s1ValidNext = accept;
        if (accept) ptrNext = ptr + (AW+1)'(1);
        if (finish) stateNext = DONE;
      end
      default: begin
        if (i_start) begin
          stateNext      = RUN;
          ptrNext        = '0;
          numEntNext     = i_num_entries;
          stopOnFailNext = i_stop_on_fail;
          checksNext     = '0;
          passesNext     = '0;
          failValidNext  = 1'b0;
          failIndexNext  = '0;
          failChNext     = '0;
          failActNext    = '0;
          failExpNext    = '0;
          overrunNext    = 1'b0;
        end else if (state == DONE && i_commit_valid) begin
          overrunNext = 1'b1;
        end
      end
    endcase
    busyNext = (stateNext == RUN);
    doneNext = (stateNext == DONE);
    passNext = doneNext && !failValidNext;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ptr             <= '0;
      numEnt          <= '0;
      stopOnFail      <= 1'b0;
      s1Valid         <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_pass          <= 1'b0;
      o_num_checks    <= '0;
      o_num_passes    <= '0;
      o_fail_valid    <= 1'b0;
      o_fail_index    <= '0;
      o_fail_ch       <= '0;
      o_fail_actual   <= '0;
      o_fail_expected <= '0;
      o_overrun       <= 1'b0;
    end else begin
      state           <= stateNext;
      ptr             <= ptrNext;
      numEnt          <= numEntNext;
      stopOnFail      <= stopOnFailNext;
      s1Valid         <= s1ValidNext;
      o_busy          <= busyNext;
      o_done          <= doneNext;
      o_pass          <= passNext;
      o_num_checks    <= checksNext;
      o_num_passes    <= passesNext;
      o_fail_valid    <= failValidNext;
      o_fail_index    <= failIndexNext;
      o_fail_ch       <= failChNext;
      o_fail_actual   <= failActNext;
      o_fail_expected <= failExpNext;
      o_overrun       <= overrunNext;
    end
  end

  // Expectation table and stage-1 capture; table content survives reset
  always_ff @(posedge clk) begin
    if (i_load_en && state != RUN) begin
      tblData[i_load_addr] <= i_load_data;
      tblMask[i_load_addr] <= i_load_mask;
    end
    if (accept) begin
      s1Data  <= i_commit_data;
      s1Exp   <= tblData[ptr[AW-1:0]];
      s1Mask  <= tblMask[ptr[AW-1:0]];
      s1Index <= ptr[AW-1:0];
    end
  end

endmodule

// File: tb/tb_klp32_commit_checker.sv
// Directed bench for klp32_commit_checker: transaction-level reference model
// compared every cycle, plus literal expectations for each scenario.
module tb_klp32_commit_checker;

  localparam int CNTMAX = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_load_en = 1'b0;
  logic [5:0]  i_load_addr = '0;
  logic [63:0] i_load_data = '0;
  logic [1:0]  i_load_mask = '0;
  logic [6:0]  i_num_entries = '0;
  logic        i_stop_on_fail = 1'b0;
  logic        i_start = 1'b0;
  logic        i_commit_valid = 1'b0;
  logic [63:0] i_commit_data = '0;
  logic        o_busy, o_done, o_pass, o_fail_valid, o_overrun;
  logic [3:0]  o_num_checks, o_num_passes;
  logic [5:0]  o_fail_index;
  logic [0:0]  o_fail_ch;
  logic [31:0] o_fail_actual, o_fail_expected;

  klp32_commit_checker #(.XLEN(32), .NUM_CH(2), .DEPTH(64), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .i_load_en(i_load_en), .i_load_addr(i_load_addr), .i_load_data(i_load_data),
    .i_load_mask(i_load_mask), .i_num_entries(i_num_entries),
    .i_stop_on_fail(i_stop_on_fail), .i_start(i_start),
    .i_commit_valid(i_commit_valid), .i_commit_data(i_commit_data),
    .o_busy(o_busy), .o_done(o_done), .o_pass(o_pass),
    .o_num_checks(o_num_checks), .o_num_passes(o_num_passes),
    .o_fail_valid(o_fail_valid), .o_fail_index(o_fail_index), .o_fail_ch(o_fail_ch),
    .o_fail_actual(o_fail_actual), .o_fail_expected(o_fail_expected),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nBad = 0;
  bit cmpEn = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: run = ordered list of pending commits, each judged one edge later
  typedef struct { int idx; logic [63:0] data; } pend_t;
  pend_t pq[$];
  logic [31:0] mExp [64][2];
  logic [1:0]  mMask [64];
  int mState, mChecks, mPasses, mFailIdx, mFailCh, mWant, mAccepted;
  bit mFailValid, mOverrun, mSof;
  logic [31:0] mFailAct, mFailExp;

  task automatic modelReset();
    mState = 0; mChecks = 0; mPasses = 0; mFailIdx = 0; mFailCh = 0;
    mWant = 0; mAccepted = 0; mFailValid = 0; mOverrun = 0; mSof = 0;
    mFailAct = 0; mFailExp = 0;
    pq.delete();
  endtask

  task automatic modelStep();
    pend_t p;
    bit bad;
    bit fin;
    fin = 0;
    if (mState != 1 && i_load_en) begin
      mExp[i_load_addr][0] = i_load_data[31:0];
      mExp[i_load_addr][1] = i_load_data[63:32];
      mMask[i_load_addr]   = i_load_mask;
    end
    if (mState != 1) begin
      if (i_start) begin
        modelReset();
        mState = 1; mWant = int'(i_num_entries); mSof = i_stop_on_fail;
      end else if (mState == 2 && i_commit_valid) begin
        mOverrun = 1;
      end
    end else if (mWant == 0) begin
      mState = 2;
    end else begin
      if (pq.size() > 0) begin
        p = pq.pop_front();
        bad = 0;
        for (int ch = 0; ch < 2; ch++) begin
          if (mMask[p.idx][ch]) begin
            if (mChecks < CNTMAX) mChecks++;
            if (p.data[ch*32 +: 32] == mExp[p.idx][ch]) begin
              if (mPasses < CNTMAX) mPasses++;
            end else begin
              bad = 1;
              if (!mFailValid) begin
                mFailValid = 1; mFailIdx = p.idx; mFailCh = ch;
                mFailAct = p.data[ch*32 +: 32]; mFailExp = mExp[p.idx][ch];
              end
            end
          end
        end
        fin = (p.idx == mWant - 1) || (mSof && bad);
      end
      if (!fin && i_commit_valid && mAccepted < mWant) begin
        p.idx = mAccepted; p.data = i_commit_data;
        pq.push_back(p);
        mAccepted++;
      end
      if (fin) begin
        mState = 2;
        pq.delete();
      end
    end
  endtask

  always @(posedge clk) begin
    if (!reset) modelReset();
    else modelStep();
  end

  always @(negedge reset) modelReset();

  always @(negedge clk) begin
    if (cmpEn) begin
      chk("busy", o_busy, mState == 1);
      chk("done", o_done, mState == 2);
      chk("pass", o_pass, mState == 2 && !mFailValid);
      chk("checks", o_num_checks, mChecks);
      chk("passes", o_num_passes, mPasses);
      chk("fail_valid", o_fail_valid, mFailValid);
      chk("fail_index", o_fail_index, mFailIdx);
      chk("fail_ch", o_fail_ch, mFailCh);
      chk("fail_actual", o_fail_actual, mFailAct);
      chk("fail_expected", o_fail_expected, mFailExp);
      chk("overrun", o_overrun, mOverrun);
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic load(input int a, input logic [31:0] d1, input logic [31:0] d0, input logic [1:0] m);
    i_load_en = 1'b1; i_load_addr = 6'(a); i_load_data = {d1, d0}; i_load_mask = m;
    cyc();
    i_load_en = 1'b0;
  endtask

  task automatic start(input int n, input bit sof);
    i_start = 1'b1; i_num_entries = 7'(n); i_stop_on_fail = sof;
    cyc();
    i_start = 1'b0;
  endtask

  task automatic commit(input logic [31:0] d1, input logic [31:0] d0);
    i_commit_valid = 1'b1; i_commit_data = {d1, d0};
    cyc();
    i_commit_valid = 1'b0;
  endtask

  task automatic waitDone(input string name, input int budget);
    int k;
    k = 0;
    while (!o_done && k < budget) begin cyc(); k++; end
    chk(name, o_done, 1'b1);
  endtask

  task automatic loadBase();
    load(0, 32'h11, 32'h10, 2'b11);
    load(1, 32'h21, 32'h20, 2'b11);
    load(2, 32'h31, 32'h30, 2'b11);
  endtask

  initial begin
    modelReset();
    cyc(); cyc();
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_checks", o_num_checks, 0);
    cmpEn = 1'b1;
    reset = 1'b1;
    cyc();

    // all match, back-to-back
    loadBase();
    start(3, 0);
    chk("s1_busy", o_busy, 1);
    commit(32'h11, 32'h10); commit(32'h21, 32'h20); commit(32'h31, 32'h30);
    chk("s1_done_early", o_done, 0);
    cyc();
    chk("s1_done", o_done, 1);
    chk("s1_pass", o_pass, 1);
    chk("s1_checks", o_num_checks, 6);
    chk("s1_passes", o_num_passes, 6);
    chk("s1_fail_valid", o_fail_valid, 0);

    // entry 1 ch1 expected 5 observed 8, continue on fail
    load(1, 32'h5, 32'h20, 2'b11);
    start(3, 0);
    commit(32'h11, 32'h10); commit(32'h8, 32'h20); commit(32'h31, 32'h30);
    cyc();
    chk("s2_done", o_done, 1);
    chk("s2_pass", o_pass, 0);
    chk("s2_checks", o_num_checks, 6);
    chk("s2_passes", o_num_passes, 5);
    chk("s2_fail_index", o_fail_index, 1);
    chk("s2_fail_ch", o_fail_ch, 1);
    chk("s2_fail_actual", o_fail_actual, 32'h8);
    chk("s2_fail_expected", o_fail_expected, 32'h5);

    // stop on fail: entry 2 discarded
    start(3, 1);
    commit(32'h11, 32'h10); commit(32'h8, 32'h20); commit(32'h31, 32'h30);
    chk("s3_done", o_done, 1);
    chk("s3_checks", o_num_checks, 4);
    chk("s3_passes", o_num_passes, 3);
    cyc();
    chk("s3_checks_hold", o_num_checks, 4);
    chk("s3_fail_index", o_fail_index, 1);

    // ch1 masked off and mismatching
    for (int i = 0; i < 3; i++) load(i, 32'hAA, 32'h40 + i, 2'b01);
    start(3, 0);
    for (int i = 0; i < 3; i++) commit(32'hBB, 32'h40 + i);
    cyc();
    chk("s4_checks", o_num_checks, 3);
    chk("s4_passes", o_num_passes, 3);
    chk("s4_pass", o_pass, 1);

    // zero entries, overrun, restart clears overrun
    start(0, 0);
    chk("s5_busy", o_busy, 1);
    cyc();
    chk("s5_done", o_done, 1);
    chk("s5_pass", o_pass, 1);
    chk("s5_checks", o_num_checks, 0);
    commit(32'h1, 32'h2);
    chk("s5_overrun", o_overrun, 1);
    start(0, 0);
    chk("s5_overrun_clr", o_overrun, 0);
    cyc();

    // same-cycle load and start
    i_load_en = 1'b1; i_load_addr = 6'd0; i_load_data = {32'h77, 32'h70}; i_load_mask = 2'b11;
    start(1, 0);
    i_load_en = 1'b0;
    commit(32'h77, 32'h70);
    cyc();
    chk("s6_pass", o_pass, 1);
    chk("s6_passes", o_num_passes, 2);

    // commit beyond num_entries in RUN is neither accepted nor an overrun
    load(1, 32'h21, 32'h20, 2'b11);
    start(2, 0);
    commit(32'h77, 32'h70); commit(32'h21, 32'h20); commit(32'h99, 32'h99);
    cyc();
    chk("s7_checks", o_num_checks, 4);
    chk("s7_overrun", o_overrun, 0);
    chk("s7_pass", o_pass, 1);

    // counter saturation at 15
    for (int i = 0; i < 8; i++) load(i, 32'(2*i + 1), 32'(2*i), 2'b11);
    start(8, 0);
    for (int i = 0; i < 8; i++) commit(32'(2*i + 1), 32'(2*i));
    waitDone("s8_done_wait", 5);
    chk("s8_checks_sat", o_num_checks, 15);
    chk("s8_passes_sat", o_num_passes, 15);
    chk("s8_pass", o_pass, 1);

    // reset mid-run, then reloaded run
    loadBase();
    start(3, 0);
    commit(32'h11, 32'h10);
    cyc();
    chk("s9_pre_checks", o_num_checks, 2);
    #2 reset = 1'b0;
    #1;
    chk("s9_rst_busy", o_busy, 0);
    chk("s9_rst_checks", o_num_checks, 0);
    chk("s9_rst_passes", o_num_passes, 0);
    chk("s9_rst_done", o_done, 0);
    cyc();
    reset = 1'b1;
    cyc();
    loadBase();
    start(3, 0);
    commit(32'h11, 32'h10); commit(32'h21, 32'h20); commit(32'h31, 32'h30);
    waitDone("s9_done_wait", 5);
    chk("s9_checks", o_num_checks, 6);
    chk("s9_pass", o_pass, 1);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
